// File: rtl/counter_bus_master.sv
// Purpose: master end of a half-duplex counter digit bus; samples the counter, presets it on request.
// Latency: sample lags the bus by one cycle; an accepted load commits 3 cycles later (DRIVE, TURN, capture).
// Backpressure: load_req is only honoured in SAMPLE; requests during DRIVE/TURN are dropped, not queued.
module counter_bus_master #(
    parameter int WIDTH     = 4,
    parameter int MAX_VALUE = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_req,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_busy,
    output logic             load_done,
    output logic             load_err,
    output logic             set,
    inout  wire  [WIDTH-1:0] number,
    output logic [WIDTH-1:0] sample,
    output logic             sample_valid,
    output logic             sample_changed
);

    typedef enum logic [1:0] {
        ST_SAMPLE = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_TURN   = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] held_q, held_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic             valid_q, valid_d;
    logic             changed_q, changed_d;
    logic             err_q, err_d;
    // hist_q: at least one capture since reset, so a comparison base exists
    logic             hist_q, hist_d;

    // Bus and strobes decode from registered state only; nothing from inputs reaches the bus.
    assign set            = (state_q == ST_DRIVE);
    assign number         = (state_q == ST_DRIVE) ? held_q : {WIDTH{1'bz}};
    assign load_busy      = (state_q != ST_SAMPLE);
    assign load_done      = (state_q == ST_TURN);
    assign load_err       = err_q;
    assign sample         = sample_q;
    assign sample_valid   = valid_q;
    assign sample_changed = changed_q;

    // Next-state: capture in SAMPLE, one-cycle drive, one-cycle turnaround back to SAMPLE.
    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        changed_d = 1'b0;
        err_d     = 1'b0;
        hist_d    = hist_q;
        case (state_q)
            ST_SAMPLE: begin
                sample_d  = number;
                valid_d   = 1'b1;
                changed_d = hist_q && (number != sample_q);
                hist_d    = 1'b1;
                if (load_req) begin
                    if (load_value <= MAX_V) begin
                        held_d  = load_value;
                        state_d = ST_DRIVE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_DRIVE: state_d = ST_TURN;
            ST_TURN:  state_d = ST_SAMPLE;
            default:  state_d = ST_SAMPLE;
        endcase
    end

    // State registers with synchronous reset; reset also discards the capture history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_SAMPLE;
            held_q    <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            err_q     <= 1'b0;
            hist_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            held_q    <= held_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            err_q     <= err_d;
            hist_q    <= hist_d;
        end
    end

endmodule

// File: tb/tb_counter_bus_master.sv
// Purpose: directed bench for counter_bus_master with a behavioural BCD counter on the shared bus.
// Latency: all checks are taken 1 time unit after a rising edge.
// Backpressure: none; the bench drives load_req directly.
module tb_counter_bus_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_req = 1'b0;
    logic [3:0] load_value = 4'd0;
    logic       load_busy, load_done, load_err, set;
    wire  [3:0] number;
    logic [3:0] sample;
    logic       sample_valid, sample_changed;

    // counter model: drives the bus whenever set is low, loads from bus when set is high
    logic       cnt_en = 1'b0;
    logic       cnt_clr = 1'b0;
    logic [3:0] cnt = 4'd0;

    int checks = 0;
    int errors = 0;

    assign number = set ? 4'bzzzz : cnt;

    always #5 clk = ~clk;

    // BCD up counter with preset from the bus
    always @(posedge clk) begin
        if (cnt_clr)     cnt <= 4'd0;
        else if (set)    cnt <= number;
        else if (cnt_en) cnt <= (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
    end

    counter_bus_master #(.WIDTH(4), .MAX_VALUE(9)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .load_value(load_value),
        .load_busy(load_busy), .load_done(load_done), .load_err(load_err), .set(set),
        .number(number), .sample(sample), .sample_valid(sample_valid),
        .sample_changed(sample_changed)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] prev;
        rst = 1'b1; cnt_en = 1'b1;
        tick(); tick();
        checks++; if (set !== 1'b0) begin errors++; $display("FAIL rst_set got %0d want 0", set); end
        checks++; if (sample !== 4'd0) begin errors++; $display("FAIL rst_sample got %0d want 0", sample); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0d want 0", sample_valid); end
        checks++; if ({load_busy, load_done, load_err, sample_changed} !== 4'b0)
            begin errors++; $display("FAIL rst_flags got %b want 0000", {load_busy, load_done, load_err, sample_changed}); end
        checks++; if (number !== 4'd2) begin errors++; $display("FAIL rst_bus got %0d want 2", number); end
        prev = number;
        rst = 1'b0;
        tick();
        checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL rel_valid got %0d want 1", sample_valid); end
        checks++; if (sample !== prev) begin errors++; $display("FAIL rel_sample got %0d want %0d", sample, prev); end
        checks++; if (sample_changed !== 1'b0) begin errors++; $display("FAIL rel_changed got %0d want 0", sample_changed); end
    endtask

    task automatic test_count_up();
        cnt_en = 1'b0; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        tick();
        cnt_en = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            checks++; if (sample !== 4'((k - 1) % 10))
                begin errors++; $display("FAIL up_sample k=%0d got %0d want %0d", k, sample, (k - 1) % 10); end
            checks++; if (sample_changed !== (k > 1))
                begin errors++; $display("FAIL up_changed k=%0d got %0d want %0d", k, sample_changed, k > 1); end
            checks++; if (number !== 4'(k % 10))
                begin errors++; $display("FAIL up_bus k=%0d got %0d want %0d", k, number, k % 10); end
        end
        cnt_en = 1'b0;
        tick();
        checks++; if (sample !== 4'd3) begin errors++; $display("FAIL stop_sample got %0d want 3", sample); end
        tick();
        checks++; if (sample_changed !== 1'b0) begin errors++; $display("FAIL stop_changed got %0d want 0", sample_changed); end
    endtask

    task automatic test_load_err();
        load_req = 1'b1; load_value = 4'd12;
        tick();
        load_req = 1'b0;
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL err_pulse got %0d want 1", load_err); end
        checks++; if ({set, load_busy} !== 2'b00) begin errors++; $display("FAIL err_set got %b want 00", {set, load_busy}); end
        checks++; if (sample !== 4'd3) begin errors++; $display("FAIL err_sample got %0d want 3", sample); end
        tick();
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL err_clear got %0d want 0", load_err); end
        checks++; if (set !== 1'b0 || number !== 4'd3)
            begin errors++; $display("FAIL err_bus got set=%0d bus=%0d want set=0 bus=3", set, number); end
    endtask

    task automatic test_load();
        load_req = 1'b1; load_value = 4'd5;
        tick();
        load_req = 1'b0;
        checks++; if ({set, load_busy, load_done} !== 3'b110)
            begin errors++; $display("FAIL drv_flags got %b want 110", {set, load_busy, load_done}); end
        checks++; if (number !== 4'd5) begin errors++; $display("FAIL drv_bus got %0d want 5", number); end
        checks++; if (sample !== 4'd3) begin errors++; $display("FAIL drv_sample got %0d want 3", sample); end
        tick();
        checks++; if ({set, load_busy, load_done} !== 3'b011)
            begin errors++; $display("FAIL turn_flags got %b want 011", {set, load_busy, load_done}); end
        checks++; if ({sample_valid, sample_changed} !== 2'b00)
            begin errors++; $display("FAIL turn_valid got %b want 00", {sample_valid, sample_changed}); end
        checks++; if (number !== 4'd5) begin errors++; $display("FAIL turn_cnt got %0d want 5", number); end
        tick();
        checks++; if ({load_busy, load_done} !== 2'b00)
            begin errors++; $display("FAIL e2_flags got %b want 00", {load_busy, load_done}); end
        checks++; if (sample !== 4'd3) begin errors++; $display("FAIL e2_sample got %0d want 3", sample); end
        tick();
        checks++; if (sample !== 4'd5 || sample_valid !== 1'b1)
            begin errors++; $display("FAIL e3_sample got %0d/%0d want 5/1", sample, sample_valid); end
        checks++; if (sample_changed !== 1'b1) begin errors++; $display("FAIL e3_changed got %0d want 1", sample_changed); end
        tick();
        checks++; if (sample_changed !== 1'b0) begin errors++; $display("FAIL e4_changed got %0d want 0", sample_changed); end
    endtask

    task automatic test_rst_in_drive();
        load_req = 1'b1; load_value = 4'd8;
        tick();
        load_req = 1'b0;
        checks++; if (set !== 1'b1) begin errors++; $display("FAIL rd_set got %0d want 1", set); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({set, load_busy, load_done} !== 3'b000)
            begin errors++; $display("FAIL rd_flags got %b want 000", {set, load_busy, load_done}); end
        checks++; if (number !== 4'd8) begin errors++; $display("FAIL rd_bus got %0d want 8", number); end
        checks++; if (sample !== 4'd0 || sample_valid !== 1'b0)
            begin errors++; $display("FAIL rd_sample got %0d/%0d want 0/0", sample, sample_valid); end
        tick();
        checks++; if (sample !== 4'd8 || sample_changed !== 1'b0)
            begin errors++; $display("FAIL rd_first got %0d/%0d want 8/0", sample, sample_changed); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL rd_done got %0d want 0", load_done); end
        tick();
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        load_req = 1'b1; load_value = 4'd7;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (sample_changed) pulses++;
            checks++; if (set !== (k % 3 == 1))
                begin errors++; $display("FAIL b2b_set k=%0d got %0d want %0d", k, set, k % 3 == 1); end
            checks++; if (load_done !== (k % 3 == 2))
                begin errors++; $display("FAIL b2b_done k=%0d got %0d want %0d", k, load_done, k % 3 == 2); end
            checks++; if (sample !== ((k < 4) ? 4'd8 : 4'd7))
                begin errors++; $display("FAIL b2b_sample k=%0d got %0d want %0d", k, sample, (k < 4) ? 8 : 7); end
        end
        load_req = 1'b0;
        checks++; if (pulses != 1) begin errors++; $display("FAIL b2b_pulses got %0d want 1", pulses); end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_load_err();
        test_load();
        test_rst_in_drive();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
